// File: rtl/sc_livescontrol.sv
// -----------------------------------------------------------------------------
// sc_livescontrol
//
// Game-state and lives controller. It sits directly after the collision
// comparator. It confirms collisions, counts down lives and freezes the
// playfield for a while after each hit. It pulses a frog respawn and reports
// game-over or win.
//
// Optional build macro: SC_LIVESCONTROL_EXTRALIFE_EN
//   When it is defined, a restart from WIN carries the lives over and adds one
//   bonus life, saturating at 2^LIVES_WIDTH-1. Restarts from IDLE or GAMEOVER
//   always load LIVES_INIT.
//   When it is undefined, every restart loads LIVES_INIT.
//
// Ports:
//   SC_LIVESCONTROL_CLOCK_50          in   system clock
//   SC_LIVESCONTROL_RESET_InHigh      in   synchronous active-high reset
//   SC_LIVESCONTROL_lose_InLow        in   collision flag, 0 = collision
//   SC_LIVESCONTROL_win_InHigh        in   frog reached goal row
//   SC_LIVESCONTROL_start_InLow       in   debounced start button, 0 = pressed
//   SC_LIVESCONTROL_lives_Out         out  remaining lives
//   SC_LIVESCONTROL_respawn_OutHigh   out  one-cycle frog reload pulse
//   SC_LIVESCONTROL_freeze_OutHigh    out  hold frog and traffic motion
//   SC_LIVESCONTROL_gameover_OutHigh  out  level: game lost
//   SC_LIVESCONTROL_win_OutHigh       out  level: game won
//
// All outputs are registers. They are loaded from the next-state decode, so
// they change on the same edge as the state and no input reaches an output
// combinationally.
// -----------------------------------------------------------------------------
module sc_livescontrol #(
  parameter int LIVES_INIT  = 3,
  parameter int LIVES_WIDTH = 2,
  parameter int CONFIRM     = 2,
  parameter int HIT_HOLD    = 25000000,
  parameter int HOLD_WIDTH  = 25
) (
  input  logic                   SC_LIVESCONTROL_CLOCK_50,
  input  logic                   SC_LIVESCONTROL_RESET_InHigh,
  input  logic                   SC_LIVESCONTROL_lose_InLow,
  input  logic                   SC_LIVESCONTROL_win_InHigh,
  input  logic                   SC_LIVESCONTROL_start_InLow,
  output logic [LIVES_WIDTH-1:0] SC_LIVESCONTROL_lives_Out,
  output logic                   SC_LIVESCONTROL_respawn_OutHigh,
  output logic                   SC_LIVESCONTROL_freeze_OutHigh,
  output logic                   SC_LIVESCONTROL_gameover_OutHigh,
  output logic                   SC_LIVESCONTROL_win_OutHigh
);

  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] RESPAWN  = 3'd1;
  localparam logic [2:0] PLAY     = 3'd2;
  localparam logic [2:0] HIT      = 3'd3;
  localparam logic [2:0] GAMEOVER = 3'd4;
  localparam logic [2:0] WIN      = 3'd5;

  // The confirm counter only has to reach CONFIRM-1.
  localparam int CONF_WIDTH = (CONFIRM > 1) ? $clog2(CONFIRM) : 1;

  localparam logic [LIVES_WIDTH-1:0] LIVES_LOAD = LIVES_WIDTH'(LIVES_INIT);
  localparam logic [LIVES_WIDTH-1:0] LIVES_ONE  = LIVES_WIDTH'(1);
  localparam logic [CONF_WIDTH-1:0]  CONF_LAST  = CONF_WIDTH'(CONFIRM - 1);
  localparam logic [CONF_WIDTH-1:0]  CONF_ONE   = CONF_WIDTH'(1);
  localparam logic [HOLD_WIDTH-1:0]  HOLD_LAST  = HOLD_WIDTH'((HIT_HOLD > 0) ? HIT_HOLD - 1 : 0);
  localparam logic [HOLD_WIDTH-1:0]  HOLD_ONE   = HOLD_WIDTH'(1);
`ifdef SC_LIVESCONTROL_EXTRALIFE_EN
  localparam logic [LIVES_WIDTH-1:0] LIVES_MAX  = '1;
`endif

  logic [2:0]             stateReg, stateNext;
  logic [LIVES_WIDTH-1:0] livesReg, livesNext;
  logic [CONF_WIDTH-1:0]  confirmReg, confirmNext;
  logic [HOLD_WIDTH-1:0]  holdReg, holdNext;
  logic                   respawnReg, freezeReg, gameoverReg, winReg;

  always_comb begin
    stateNext   = stateReg;
    livesNext   = livesReg;
    confirmNext = '0;            // held at zero everywhere except PLAY
    holdNext    = '0;            // only HIT advances the hold counter
    case (stateReg)
      IDLE: begin
        if (!SC_LIVESCONTROL_start_InLow) begin
          stateNext = RESPAWN;
          livesNext = LIVES_LOAD;
        end
      end
      RESPAWN: begin
        stateNext = PLAY;
      end
      PLAY: begin
        // A win beats a collision that is confirmed in the same cycle.
        if (SC_LIVESCONTROL_win_InHigh) begin
          stateNext = WIN;
        end else if (!SC_LIVESCONTROL_lose_InLow) begin
          if (confirmReg == CONF_LAST) begin
            stateNext = HIT;
            livesNext = (livesReg != '0) ? (livesReg - LIVES_ONE) : '0;
          end else begin
            confirmNext = confirmReg + CONF_ONE;
          end
        end
      end
      HIT: begin
        if (holdReg == HOLD_LAST) begin
          stateNext = (livesReg == '0) ? GAMEOVER : RESPAWN;
        end else begin
          holdNext = holdReg + HOLD_ONE;
        end
      end
      GAMEOVER: begin
        if (!SC_LIVESCONTROL_start_InLow) begin
          stateNext = RESPAWN;
          livesNext = LIVES_LOAD;
        end
      end
      WIN: begin
        if (!SC_LIVESCONTROL_start_InLow) begin
          stateNext = RESPAWN;
`ifdef SC_LIVESCONTROL_EXTRALIFE_EN
          livesNext = (livesReg == LIVES_MAX) ? livesReg : (livesReg + LIVES_ONE);
`else
          livesNext = LIVES_LOAD;
`endif
        end
      end
      default: begin
        stateNext = IDLE;
        livesNext = LIVES_LOAD;
      end
    endcase
  end

  always_ff @(posedge SC_LIVESCONTROL_CLOCK_50) begin
    if (SC_LIVESCONTROL_RESET_InHigh) begin
      stateReg    <= IDLE;
      livesReg    <= LIVES_LOAD;
      confirmReg  <= '0;
      holdReg     <= '0;
      respawnReg  <= 1'b0;
      freezeReg   <= 1'b1;
      gameoverReg <= 1'b0;
      winReg      <= 1'b0;
    end else begin
      stateReg    <= stateNext;
      livesReg    <= livesNext;
      confirmReg  <= confirmNext;
      holdReg     <= holdNext;
      respawnReg  <= (stateNext == RESPAWN);
      freezeReg   <= (stateNext != PLAY);
      gameoverReg <= (stateNext == GAMEOVER);
      winReg      <= (stateNext == WIN);
    end
  end

  assign SC_LIVESCONTROL_lives_Out        = livesReg;
  assign SC_LIVESCONTROL_respawn_OutHigh  = respawnReg;
  assign SC_LIVESCONTROL_freeze_OutHigh   = freezeReg;
  assign SC_LIVESCONTROL_gameover_OutHigh = gameoverReg;
  assign SC_LIVESCONTROL_win_OutHigh      = winReg;

endmodule

// File: tb/tb_sc_livescontrol.sv
// -----------------------------------------------------------------------------
// tb_sc_livescontrol
//
// Testbench for sc_livescontrol, built with HIT_HOLD = 4. A cycle-level
// behavioural model follows the game rules. It counts the streak of
// consecutive collision cycles and the freeze cycles still remaining, and
// predicts every output once per clock. Directed scenarios come first, then
// randomized play with occasional resets. Set SC_LIVESCONTROL_EXTRALIFE_EN the
// same way for the RTL and the bench.
// -----------------------------------------------------------------------------
module tb_sc_livescontrol;

  localparam int LIVES_INIT  = 3;
  localparam int LIVES_WIDTH = 2;
  localparam int CONFIRM     = 2;
  localparam int HIT_HOLD    = 4;
  localparam int HOLD_WIDTH  = 25;
  localparam int LIVES_CAP   = (1 << LIVES_WIDTH) - 1;

  // Model game phases.
  localparam int M_IDLE = 0, M_RESPAWN = 1, M_PLAY = 2, M_HIT = 3, M_OVER = 4, M_WON = 5;

  logic clk;
  logic rstIn, loseIn, winIn, startIn;
  logic [LIVES_WIDTH-1:0] livesOut;
  logic respawnOut, freezeOut, gameoverOut, winOut;

  int numChecks = 0;
  int numErrors = 0;

  int mMode, mLives, mStreak, mHoldLeft;

  sc_livescontrol #(
    .LIVES_INIT (LIVES_INIT),
    .LIVES_WIDTH(LIVES_WIDTH),
    .CONFIRM    (CONFIRM),
    .HIT_HOLD   (HIT_HOLD),
    .HOLD_WIDTH (HOLD_WIDTH)
  ) dut (
    .SC_LIVESCONTROL_CLOCK_50        (clk),
    .SC_LIVESCONTROL_RESET_InHigh    (rstIn),
    .SC_LIVESCONTROL_lose_InLow      (loseIn),
    .SC_LIVESCONTROL_win_InHigh      (winIn),
    .SC_LIVESCONTROL_start_InLow     (startIn),
    .SC_LIVESCONTROL_lives_Out       (livesOut),
    .SC_LIVESCONTROL_respawn_OutHigh (respawnOut),
    .SC_LIVESCONTROL_freeze_OutHigh  (freezeOut),
    .SC_LIVESCONTROL_gameover_OutHigh(gameoverOut),
    .SC_LIVESCONTROL_win_OutHigh     (winOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkValue(input string tag, input int observed, input int expected);
    numChecks++;
    if (observed != expected) begin
      numErrors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    mMode     = M_IDLE;
    mLives    = LIVES_INIT;
    mStreak   = 0;
    mHoldLeft = 0;
  endtask

  // Apply one clock edge worth of rules to the model.
  task automatic modelStep(input logic r, input logic lose, input logic w, input logic s);
    if (r) begin
      modelReset();
    end else begin
      case (mMode)
        M_IDLE, M_OVER: begin
          if (!s) begin
            mMode  = M_RESPAWN;
            mLives = LIVES_INIT;
          end
        end
        M_RESPAWN: begin
          mMode   = M_PLAY;
          mStreak = 0;
        end
        M_PLAY: begin
          if (w) begin
            mMode   = M_WON;
            mStreak = 0;
          end else if (!lose) begin
            mStreak++;
            if (mStreak >= CONFIRM) begin
              mMode     = M_HIT;
              mLives    = (mLives > 0) ? mLives - 1 : 0;
              mHoldLeft = HIT_HOLD;
              mStreak   = 0;
            end
          end else begin
            mStreak = 0;
          end
        end
        M_HIT: begin
          mHoldLeft--;
          if (mHoldLeft == 0) mMode = (mLives == 0) ? M_OVER : M_RESPAWN;
        end
        M_WON: begin
          if (!s) begin
            mMode = M_RESPAWN;
`ifdef SC_LIVESCONTROL_EXTRALIFE_EN
            mLives = (mLives + 1 > LIVES_CAP) ? LIVES_CAP : mLives + 1;
`else
            mLives = LIVES_INIT;
`endif
          end
        end
        default: modelReset();
      endcase
    end
  endtask

  // Compare outputs with the model, then drive the inputs for the next edge.
  task automatic cycle(input logic r, input logic lose, input logic w, input logic s);
    @(negedge clk);
    checkValue("lives",    int'(livesOut),    mLives);
    checkValue("respawn",  int'(respawnOut),  (mMode == M_RESPAWN) ? 1 : 0);
    checkValue("freeze",   int'(freezeOut),   (mMode != M_PLAY) ? 1 : 0);
    checkValue("gameover", int'(gameoverOut), (mMode == M_OVER) ? 1 : 0);
    checkValue("win",      int'(winOut),      (mMode == M_WON) ? 1 : 0);
    rstIn   = r;
    loseIn  = lose;
    winIn   = w;
    startIn = s;
    modelStep(r, lose, w, s);
    $display("cyc t=%0t rst=%0b lose=%0b win=%0b start=%0b | lives=%0d rsp=%0b frz=%0b go=%0b won=%0b",
             $time, r, lose, w, s, livesOut, respawnOut, freezeOut, gameoverOut, winOut);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  initial begin
    rstIn   = 1'b1;
    loseIn  = 1'b1;
    winIn   = 1'b0;
    startIn = 1'b1;
    repeat (2) @(posedge clk);
    modelReset();

    // Reset state, then start, respawn pulse and play.
    idleCycles(2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idleCycles(3);

    // A single-cycle glitch must not count. Two cycles low is a hit.
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idleCycles(3);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    idleCycles(HIT_HOLD + 4);

    // A confirmed collision and a win in the same cycle: the win takes priority.
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b1, 1'b1);
    idleCycles(3);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);   // restart from WIN at lives=2
    idleCycles(3);

    // A win at the current lives count, then restart.
    cycle(1'b0, 1'b1, 1'b1, 1'b1);
    idleCycles(2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);
    idleCycles(3);

    // Hold lose low until the game is lost and then some more.
    for (int i = 0; i < 60; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1);
    checkValue("go_level", int'(gameoverOut), 1);
    checkValue("go_lives", int'(livesOut), 0);
    checkValue("go_freeze", int'(freezeOut), 1);
    cycle(1'b0, 1'b1, 1'b0, 1'b0);   // restart from GAMEOVER
    idleCycles(3);

    // Reset in the middle of the HIT hold.
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    idleCycles(2);

    // Randomized play.
    for (int i = 0; i < 4000; i++) begin
      logic r, l, w, s;
      r = ($urandom_range(0, 299) == 0);
      l = ($urandom_range(0, 99) >= 30);
      w = ($urandom_range(0, 99) < 3);
      s = ($urandom_range(0, 99) >= 10);
      cycle(r, l, w, s);
    end
    idleCycles(1);

    $display("Simulation finished: %0d checks, %0d errors", numChecks, numErrors);
    $finish;
  end

endmodule
